rca_serial_sequencer: RTL and testbench
=======================================

Name: rca_serial_sequencer

Overview:
Multi-cycle controller that time-shares one narrow ripple-carry adder slice (the 2-bit rca2bit) to add or subtract full-width operands, SLICE bits per cycle, LSB first.
- The adder slice is instantiated outside this block; the sequencer drives its A/B/Cin and samples its S/Cout.
- Sits between the ALU front end (valid/ready operand handshake) and the shared adder slice.
- Produces full-width result, carry-out and signed overflow.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
SLICE, 2, adder slice width; STEPS = WIDTH/SLICE cycles per operation.

Ports:
clock  input  1  single clock, all flops rising-edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand request.
in_ready  output  1  high only in IDLE.
data_operandA  input  WIDTH  operand A, sampled on accept.
data_operandB  input  WIDTH  operand B, sampled on accept.
ctrl_sub  input  1  1 = A-B, 0 = A+B, sampled on accept.
slice_A  output  SLICE  to adder slice A.
slice_B  output  SLICE  to adder slice B (already inverted for subtract).
slice_Cin  output  1  to adder slice Cin.
slice_S  input  SLICE  from adder slice sum, combinational from slice_A/B/Cin.
slice_Cout  input  1  from adder slice carry-out.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
data_result  output  WIDTH  sum/difference.
carry_out  output  1  final carry (for subtract, 1 = no borrow).
overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, reset_n=0): state IDLE, step counter 0, carry flop 0, operand and result shift regs 0. Outputs: in_ready=1, out_valid=0, data_result=0, carry_out=0, overflow=0, slice_* = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. Accept on in_valid & in_ready at a rising edge:
  - a_reg <= A; b_reg <= ctrl_sub ? ~B : B; carry <= ctrl_sub; count <= 0.
  - Capture sign bits a_msb = A[WIDTH-1] and b_msb = B'[WIDTH-1].
  - Go to RUN.
- RUN:
  - Combinational drive: slice_A=a_reg[SLICE-1:0], slice_B=b_reg[SLICE-1:0], slice_Cin=carry.
  - Each edge:
    - a_reg and b_reg shift right by SLICE.
    - Result reg shifts right by SLICE with slice_S entering the top SLICE bits.
    - carry <= slice_Cout; count++.
  - When count == STEPS-1 at an edge: go to DONE.
  - carry_out <= slice_Cout.
  - overflow <= (a_msb == b_msb) & (slice_S[SLICE-1] != a_msb).
- Outside RUN: slice_A/B/Cin held 0.
- Latency: out_valid rises exactly STEPS edges after the accept edge (16 for defaults). The combinational path depends on the external slice only; no result bypass.
- DONE:
  - out_valid=1; data_result, carry_out and overflow are stable and held while out_ready=0 (unlimited backpressure).
  - On out_valid & out_ready at an edge: go to IDLE, out_valid=0. Result registers hold their last value.
  - in_ready=0 in RUN and DONE. in_valid there is ignored; the operands are not latched.
- No same-cycle result-out/operand-in overlap. The earliest next accept is the edge after returning to IDLE, so throughput is 1 op per STEPS+2 cycles minimum.
- Reset mid-RUN or mid-DONE: immediate abort to IDLE. All outputs return to reset values, the partial result is discarded, and no out_valid is issued.
- Inputs data_operandA/B and ctrl_sub may change freely after accept without affecting the op in flight.
- Width rules:
  - Result is modulo 2^WIDTH.
  - carry_out is the carry out of bit WIDTH-1.
  - Overflow uses the operand sign captured after B inversion, so subtract overflow is correct.

Test Plan:
- A=5, B=3, sub=0, out_ready=1 -> out_valid exactly 16 cycles after accept; result=8, carry_out=0, overflow=0; slice_Cin=0 on first RUN cycle.
- A=5, B=3, sub=1 -> result=2, carry_out=1, overflow=0; first RUN cycle slice_B=2'b00 (~3 low bits), slice_Cin=1.
- A=0x7FFFFFFF, B=1, sub=0 -> result=0x80000000, overflow=1, carry_out=0; A=0xFFFFFFFF, B=1 -> result=0, carry_out=1, overflow=0.
- A=0x80000000, B=1, sub=1 -> result=0x7FFFFFFF, overflow=1, carry_out=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and new operands -> result constant, in_ready=0, no new accept. Then out_ready=1 -> IDLE, accept one cycle later.
- Deassert reset_n for one cycle at RUN step 7 -> asynchronously in_ready=1, out_valid=0, slice_* = 0, data_result=0. A following op A=10, B=20 completes correctly with result=30.

Source files
------------

// File: rtl/rca_serial_sequencer.sv
// rca_serial_sequencer: adds or subtracts full-width operands by driving an
// external SLICE-bit ripple-carry adder slice for WIDTH/SLICE cycles, LSB first.
module rca_serial_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_sub,
   output logic [SLICE-1:0] slice_A,
   output logic [SLICE-1:0] slice_B,
   output logic             slice_Cin,
   input  logic [SLICE-1:0] slice_S,
   input  logic             slice_Cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned STEPS = WIDTH / SLICE;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic             cout_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] b_in_d;
   logic [WIDTH-1:0] res_d;
   logic             ovf_d;

   // Operand B as it enters the datapath (one's complement for subtract)
   always_comb begin
      b_in_d = data_operandB;
      if (ctrl_sub) begin
         b_in_d = ~data_operandB;
      end
   end

   // Next partial result and overflow from the current slice output
   always_comb begin
      res_d = (res_q >> SLICE) | (WIDTH'(slice_S) << (WIDTH - SLICE));
      ovf_d = (a_msb_q == b_msb_q) & (slice_S[SLICE-1] != a_msb_q);
   end

   // Drive the shared adder slice only while an operation is running
   always_comb begin
      slice_A   = '0;
      slice_B   = '0;
      slice_Cin = 1'b0;
      if (state_q == ST_RUN) begin
         slice_A   = a_q[SLICE-1:0];
         slice_B   = b_q[SLICE-1:0];
         slice_Cin = carry_q;
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= data_operandA;
                  b_q        <= b_in_d;
                  carry_q    <= ctrl_sub;
                  cnt_q      <= '0;
                  a_msb_q    <= data_operandA[WIDTH-1];
                  b_msb_q    <= b_in_d[WIDTH-1];
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> SLICE;
               b_q     <= b_q >> SLICE;
               res_q   <= res_d;
               carry_q <= slice_Cout;
               cnt_q   <= cnt_q + CNT_W'(1);
               cout_q  <= slice_Cout;
               ovf_q   <= ovf_d;
               if (cnt_q == LAST_STEP) begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign data_result = res_q;
   assign carry_out   = cout_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_rca_serial_sequencer.sv
// Testbench for rca_serial_sequencer: behavioural 2-bit adder slice, directed
// operations with hand-computed results, scoreboard queue checked by a monitor.
module tb_rca_serial_sequencer;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_sub;
   logic [1:0]  slice_A;
   logic [1:0]  slice_B;
   logic        slice_Cin;
   logic [1:0]  slice_S;
   logic        slice_Cout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_result;
   logic        carry_out;
   logic        overflow;

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   accept_cyc = 0;
   logic prev_valid = 1'b0;

   rca_serial_sequencer #(.WIDTH(32), .SLICE(2)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_operandA(data_operandA),
      .data_operandB(data_operandB),
      .ctrl_sub     (ctrl_sub),
      .slice_A      (slice_A),
      .slice_B      (slice_B),
      .slice_Cin    (slice_Cin),
      .slice_S      (slice_S),
      .slice_Cout   (slice_Cout),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .data_result  (data_result),
      .carry_out    (carry_out),
      .overflow     (overflow)
   );

   // External 2-bit ripple-carry adder slice
   assign {slice_Cout, slice_S} = 3'(slice_A) + 3'(slice_B) + 3'(slice_Cin);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: latency on out_valid rise, result compare on handshake
   always @(negedge clock) begin
      if (reset_n) begin
         if (out_valid && !prev_valid) begin
            check("latency", 32'(cyc - accept_cyc), 32'd16);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got 0x%08h expected none", data_result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", data_result, e.res);
               check("carry_out", 32'(carry_out), 32'(e.c));
               check("overflow", 32'(overflow), 32'(e.v));
            end
         end
      end
      prev_valid = out_valid;
   end

   // Issue one operation and check the first RUN-cycle slice drive
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] er, input logic ec, input logic ev,
                        input logic [1:0] fa, input logic [1:0] fb, input logic fcin);
      int n;
      exp_t e;
      in_valid      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      ctrl_sub      = sub;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
      e.res = er;
      e.c   = ec;
      e.v   = ev;
      sb.push_back(e);
      @(posedge clock); #1;
      accept_cyc    = cyc;
      in_valid      = 1'b0;
      data_operandA = ~a;
      data_operandB = ~b;
      ctrl_sub      = ~sub;
      check("first_slice_A", 32'(slice_A), 32'(fa));
      check("first_slice_B", 32'(slice_B), 32'(fb));
      check("first_slice_Cin", 32'(slice_Cin), 32'(fcin));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(posedge clock); #1;
   endtask

   initial begin
      logic [31:0] hold;
      int          n;
      exp_t        e;
      reset_n       = 1'b0;
      in_valid      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      ctrl_sub      = 1'b0;
      out_ready     = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", data_result, 32'd0);
      check("rst_carry", 32'(carry_out), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_slices", {29'd0, slice_A, slice_B[0] | slice_B[1] | slice_Cin}, 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      issue(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 2'b01, 2'b11, 1'b0);
      wait_drain();
      issue(32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
      wait_drain();
      issue(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 2'b11, 2'b01, 1'b0);
      wait_drain();
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0);
      wait_drain();
      issue(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 2'b00, 2'b10, 1'b1);
      wait_drain();

      // Backpressure: result held, new request ignored until handshake
      out_ready = 1'b0;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check("bp_valid_seen", 32'(out_valid), 32'd1);
      in_valid      = 1'b1;
      data_operandA = 32'h0000_0100;
      data_operandB = 32'h0000_0001;
      ctrl_sub      = 1'b1;
      hold          = data_result;
      repeat (10) begin
         @(posedge clock); #1;
         check("bp_result_hold", data_result, hold);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_idle_in_ready", 32'(in_ready), 32'd1);
      check("bp_idle_out_valid", 32'(out_valid), 32'd0);
      e.res = 32'h0000_00FF;
      e.c   = 1'b1;
      e.v   = 1'b0;
      sb.push_back(e);
      @(posedge clock); #1;
      accept_cyc = cyc;
      in_valid   = 1'b0;
      check("bp_accepted", 32'(in_ready), 32'd0);
      wait_drain();

      // Asynchronous reset at RUN step 7 aborts the operation
      issue(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0);
      repeat (7) begin
         @(posedge clock); #1;
      end
      check("pre_abort_partial_nonzero", 32'(data_result != 32'd0), 32'd1);
      reset_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_slices", {29'd0, slice_A, slice_B[0] | slice_B[1] | slice_Cin}, 32'd0);
      check("abort_result", data_result, 32'd0);
      sb.delete();
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (20) begin
         @(posedge clock); #1;
         check("abort_no_valid", 32'(out_valid), 32'd0);
      end
      issue(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
      wait_drain();

      repeat (3) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
